dir_input_ctrl: RTL and testbench

DIR_INPUT_CTRL -- requirements
Module: dir_input_ctrl

---
 rtl/snake_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 54 +++++
 rtl/dir_input_ctrl.sv | 125 ++++++++++++
 tb/tb_dir_input_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared direction encoding for the snake game: 2-bit direction type,
// its four named values and the opposite-direction helper.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  function automatic dir_t opposite(input dir_t d);
    dir_t o;
    case (d)
      DIR_UP:   o = DIR_DOWN;
      DIR_DOWN: o = DIR_UP;
      DIR_LEFT: o = DIR_RIGHT;
      default:  o = DIR_LEFT;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-flop synchronizer, stability counter, debounced level
// and a one-cycle pulse the cycle after the debounced level rises.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned CNT_W           = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      cnt_q        <= cnt_d;
      stable_dly_q <= stable_q;
      press_q      <= stable_q & ~stable_dly_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/dir_input_ctrl.sv
// Debounced four-button direction input with a turn queue drained on tick.
// DIR_QUEUE_EN defined: two-entry queue; undefined: single overwriting slot.
module dir_input_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned CNT_W           = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       tick,
  output logic [1:0] dir,
  output logic [3:0] press,
  output logic [1:0] pending
);

  logic [3:0] press_w;
  logic [3:0] btn_w;

  assign btn_w = {btnU, btnD, btnL, btnR};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_i  (btn_w[i]),
      .press_o(press_w[i])
    );
  end

  dir_t       dir_q, dir_d;
  dir_t       q0_q, q0_d;
  logic [1:0] pend_q, pend_d;
  logic [1:0] pend_mid;
  logic       cand_vld;
  dir_t       cand;
  dir_t       ref_dir;
  logic       accept;
`ifdef DIR_QUEUE_EN
  dir_t       q1_q, q1_d;
  dir_t       q0_mid, q1_mid;
`endif

  always_comb begin
    cand_vld = |press_w;
    if (press_w[3])      cand = DIR_UP;
    else if (press_w[2]) cand = DIR_DOWN;
    else if (press_w[1]) cand = DIR_LEFT;
    else                 cand = DIR_RIGHT;
  end

  // Pop happens first so a same-cycle candidate is judged against the
  // post-pop reference and pushed in the same edge.
  always_comb begin
    dir_d  = dir_q;
    q0_d   = q0_q;
    pend_d = pend_q;
`ifdef DIR_QUEUE_EN
    q1_d     = q1_q;
    q0_mid   = q0_q;
    q1_mid   = q1_q;
    pend_mid = pend_q;
    if (tick && pend_q != 2'd0) begin
      dir_d    = q0_q;
      q0_mid   = q1_q;
      pend_mid = pend_q - 2'd1;
    end
    if (pend_mid == 2'd2)      ref_dir = q1_mid;
    else if (pend_mid == 2'd1) ref_dir = q0_mid;
    else                       ref_dir = dir_d;
    accept = cand_vld && (cand != ref_dir) && (cand != opposite(ref_dir));
    q0_d   = q0_mid;
    q1_d   = q1_mid;
    pend_d = pend_mid;
    if (accept && pend_mid != 2'd2) begin
      if (pend_mid == 2'd0) q0_d = cand;
      else                  q1_d = cand;
      pend_d = pend_mid + 2'd1;
    end
`else
    pend_mid = pend_q;
    if (tick && pend_q != 2'd0) begin
      dir_d    = q0_q;
      pend_mid = 2'd0;
    end
    ref_dir = dir_d;
    accept  = cand_vld && (cand != ref_dir) && (cand != opposite(ref_dir));
    pend_d  = pend_mid;
    if (accept) begin
      q0_d   = cand;
      pend_d = 2'd1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q  <= DIR_RIGHT;
      q0_q   <= DIR_UP;
      pend_q <= 2'd0;
`ifdef DIR_QUEUE_EN
      q1_q   <= DIR_UP;
`endif
    end else begin
      dir_q  <= dir_d;
      q0_q   <= q0_d;
      pend_q <= pend_d;
`ifdef DIR_QUEUE_EN
      q1_q   <= q1_d;
`endif
    end
  end

  assign dir     = dir_q;
  assign press   = press_w;
  assign pending = pend_q;

endmodule

// File: tb/tb_dir_input_ctrl.sv
// Directed bench for dir_input_ctrl with DEBOUNCE_CYCLES=16; press pulses are
// checked against a scoreboard of expected vectors and arrival cycles.
module tb_dir_input_ctrl;

  localparam int unsigned DC  = 16;
  localparam int unsigned LAT = DC + 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btns = 4'b0000;
  logic       tick = 1'b0;
  logic [1:0] dir;
  logic [3:0] press;
  logic [1:0] pending;

  int unsigned cyc = 0;
  int          compared = 0;
  int          mismatched = 0;

  typedef struct {
    logic [3:0]  vec;
    int unsigned at;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  dir_input_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btnU   (btns[3]),
    .btnD   (btns[2]),
    .btnL   (btns[1]),
    .btnR   (btns[0]),
    .tick   (tick),
    .dir    (dir),
    .press  (press),
    .pending(pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && press !== 4'b0000) begin
      if (sb.size() == 0) begin
        compared++;
        assert (press === 4'b0000)
        else begin
          mismatched++;
          $error("FAIL spurious_press observed=%b expected=0000 cyc=%0d", press, cyc);
        end
      end else begin
        mon_e = sb.pop_front();
        compared++;
        assert (press === mon_e.vec)
        else begin
          mismatched++;
          $error("FAIL press_vec observed=%b expected=%b cyc=%0d", press, mon_e.vec, cyc);
        end
        compared++;
        assert (cyc === mon_e.at)
        else begin
          mismatched++;
          $error("FAIL press_cycle observed=%0d expected=%0d", cyc, mon_e.at);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic expect_press(input logic [3:0] v);
    exp_t e;
    e.vec = v;
    e.at  = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic push_btn(input logic [3:0] m);
    expect_press(m);
    btns = m;
    step(20);
    btns = 4'b0000;
    step(20);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
  endtask

  initial begin
    step(3);
    chk("reset_dir", {2'b00, dir}, 4'b0011);
    chk("reset_pending", {2'b00, pending}, 4'b0000);
    chk("reset_press", press, 4'b0000);
    rst_n = 1'b1;
    step(2);

    // single U press then tick
    push_btn(4'b1000);
    chk("u_pending", {2'b00, pending}, 4'b0001);
    chk("u_dir_before_tick", {2'b00, dir}, 4'b0011);
    do_tick();
    chk("u_dir_after_tick", {2'b00, dir}, 4'b0000);
    chk("u_pending_after_tick", {2'b00, pending}, 4'b0000);
    push_btn(4'b0001);
    do_tick();
    chk("back_to_right", {2'b00, dir}, 4'b0011);

    // glitch shorter than the debounce interval
    btns = 4'b0010;
    step(10);
    btns = 4'b0000;
    step(25);
    chk("glitch_pending", {2'b00, pending}, 4'b0000);
    chk("glitch_dir", {2'b00, dir}, 4'b0011);

    // rejection and overflow
    push_btn(4'b0010);
    chk("l_vs_right_rejected", {2'b00, pending}, 4'b0000);
    push_btn(4'b1000);
    chk("u_accepted", {2'b00, pending}, 4'b0001);
    push_btn(4'b0100);
    chk("d_after_u", {2'b00, pending}, 4'b0001);
    push_btn(4'b1000);
    push_btn(4'b0001);
`ifdef DIR_QUEUE_EN
    chk("ur_pending", {2'b00, pending}, 4'b0010);
`else
    chk("ur_pending", {2'b00, pending}, 4'b0001);
`endif
    push_btn(4'b0100);
`ifdef DIR_QUEUE_EN
    chk("d_dropped_full", {2'b00, pending}, 4'b0010);
    do_tick();
    chk("pop1_dir", {2'b00, dir}, 4'b0000);
    chk("pop1_pending", {2'b00, pending}, 4'b0001);
    do_tick();
    chk("pop2_dir", {2'b00, dir}, 4'b0011);
`else
    chk("d_overwrites", {2'b00, pending}, 4'b0001);
    do_tick();
    chk("pop1_dir", {2'b00, dir}, 4'b0001);
    chk("pop1_pending", {2'b00, pending}, 4'b0000);
    do_tick();
    chk("pop2_dir", {2'b00, dir}, 4'b0001);
`endif
    chk("drained_pending", {2'b00, pending}, 4'b0000);
    do_reset();

    // tick coincident with a press
    push_btn(4'b1000);
    push_btn(4'b0010);
`ifdef DIR_QUEUE_EN
    chk("ul_pending", {2'b00, pending}, 4'b0010);
`else
    chk("ul_pending", {2'b00, pending}, 4'b0001);
`endif
    expect_press(4'b0001);
    btns = 4'b0001;
    step(LAT);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    chk("coinc_dir", {2'b00, dir}, 4'b0000);
    chk("coinc_pending", {2'b00, pending}, 4'b0001);
    btns = 4'b0000;
    step(20);
    do_tick();
`ifdef DIR_QUEUE_EN
    chk("coinc_next_dir", {2'b00, dir}, 4'b0010);
`else
    chk("coinc_next_dir", {2'b00, dir}, 4'b0011);
`endif
    do_reset();

    // simultaneous U and R with dir=LEFT
    push_btn(4'b1000);
    do_tick();
    push_btn(4'b0010);
    do_tick();
    chk("dir_left", {2'b00, dir}, 4'b0010);
    push_btn(4'b1001);
    chk("simul_pending", {2'b00, pending}, 4'b0001);
    do_tick();
    chk("simul_dir", {2'b00, dir}, 4'b0000);
    do_reset();

    // U then D before tick
    push_btn(4'b1000);
    push_btn(4'b0100);
    chk("ud_pending", {2'b00, pending}, 4'b0001);
    do_tick();
`ifdef DIR_QUEUE_EN
    chk("ud_dir", {2'b00, dir}, 4'b0000);
`else
    chk("ud_dir", {2'b00, dir}, 4'b0001);
`endif
    do_reset();

    // reset mid-debounce with a queued state, D held through release
    push_btn(4'b1000);
    push_btn(4'b0010);
    btns = 4'b0100;
    step(8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_dir", {2'b00, dir}, 4'b0011);
    chk("midrst_pending", {2'b00, pending}, 4'b0000);
    chk("midrst_press", press, 4'b0000);
    step(2);
    rst_n = 1'b1;
    expect_press(4'b0100);
    step(20);
    btns = 4'b0000;
    step(20);
    chk("held_d_pending", {2'b00, pending}, 4'b0001);
    do_tick();
    chk("held_d_dir", {2'b00, dir}, 4'b0001);

    step(5);
    compared++;
    assert (sb.size() === 0)
    else begin
      mismatched++;
      $error("FAIL missing_press observed=%0d expected=0 outstanding", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
